// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: state encoding, field width/limit, next-state and wrap helpers.
package stopwatch_pkg;

   localparam int FIELD_W     = 6;
   localparam int MAX_VAL_DEF = 59;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_ADJUST = 2'd2
   } state_t;

   // Adjust overrides everything; leaving adjust always parks the stopwatch paused.
   function automatic state_t next_state(input state_t cur, input logic adjust,
                                         input logic pause_pulse);
      state_t nxt;
      if (adjust)
         nxt = ST_ADJUST;
      else if (cur == ST_ADJUST)
         nxt = ST_PAUSED;
      else if (cur == ST_RUN)
         nxt = pause_pulse ? ST_PAUSED : ST_RUN;
      else if (cur == ST_PAUSED)
         nxt = pause_pulse ? ST_RUN : ST_PAUSED;
      else
         nxt = ST_RUN;
      return nxt;
   endfunction

   function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                   input logic [FIELD_W-1:0] max_v);
      return (v >= max_v) ? '0 : v + FIELD_W'(1);
   endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector: one-cycle pulse, combinational from the level and a one-flop history.
module rise_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic prev;

   always_ff @(posedge clk) begin
      if (reset)
         prev <= 1'b0;
      else
         prev <= level;
   end

   assign pulse = level & ~prev;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch minutes/seconds with run/pause/adjust FSM; field updates visible one cycle after a tick.
// Optional lap freeze of the displayed value is built when STOPWATCH_LAP_EN is defined.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int ADJ_DIV  = 2,
   parameter int MAX_VAL  = MAX_VAL_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pauseBtn,
   input  logic               adjust,
   input  logic               select,
`ifdef STOPWATCH_LAP_EN
   input  logic               lapBtn,
   output logic               lapActive,
`endif
   output logic [FIELD_W-1:0] minutes,
   output logic [FIELD_W-1:0] seconds,
   output logic               paused,
   output logic               adjusting
);

   localparam int ADJ_PERIOD = (CLK_FREQ / ADJ_DIV >= 1) ? CLK_FREQ / ADJ_DIV : 1;
   localparam int SEC_W      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam int ADJ_W      = (ADJ_PERIOD > 1) ? $clog2(ADJ_PERIOD) : 1;
   localparam logic [SEC_W-1:0]   SEC_LAST = SEC_W'(CLK_FREQ - 1);
   localparam logic [ADJ_W-1:0]   ADJ_LAST = ADJ_W'(ADJ_PERIOD - 1);
   localparam logic [FIELD_W-1:0] MAX_F    = FIELD_W'(MAX_VAL);

   state_t             state;
   state_t             nxt;
   logic               pause_pulse;
   logic [SEC_W-1:0]   sec_div;
   logic [ADJ_W-1:0]   adj_div;
   logic               sec_tick;
   logic               adj_tick;
   logic [FIELD_W-1:0] live_min;
   logic [FIELD_W-1:0] live_sec;

   rise_edge_detect u_pause_edge (
      .clk   (clk),
      .reset (reset),
      .level (pauseBtn),
      .pulse (pause_pulse)
   );

   assign nxt      = next_state(state, adjust, pause_pulse);
   assign sec_tick = (state == ST_RUN) && (sec_div == SEC_LAST);
   assign adj_tick = (state == ST_ADJUST) && (adj_div == ADJ_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         paused    <= 1'b0;
         adjusting <= 1'b0;
      end else begin
         state     <= nxt;
         paused    <= (nxt == ST_PAUSED);
         adjusting <= (nxt == ST_ADJUST);
      end
   end

   // Prescalers only advance in their own state, so resuming always costs a full period.
   always_ff @(posedge clk) begin
      if (reset) begin
         sec_div <= '0;
         adj_div <= '0;
      end else begin
         if (state != ST_RUN || sec_tick)
            sec_div <= '0;
         else
            sec_div <= sec_div + SEC_W'(1);

         if (state != ST_ADJUST || adj_tick)
            adj_div <= '0;
         else
            adj_div <= adj_div + ADJ_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         live_min <= '0;
         live_sec <= '0;
      end else if (sec_tick) begin
         live_sec <= wrap_inc(live_sec, MAX_F);
         if (live_sec >= MAX_F)
            live_min <= wrap_inc(live_min, MAX_F);
      end else if (adj_tick) begin
         if (select)
            live_sec <= wrap_inc(live_sec, MAX_F);
         else
            live_min <= wrap_inc(live_min, MAX_F);
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic               lap_pulse;
   logic               lap_active;
   logic [FIELD_W-1:0] lap_min;
   logic [FIELD_W-1:0] lap_sec;

   rise_edge_detect u_lap_edge (
      .clk   (clk),
      .reset (reset),
      .level (lapBtn),
      .pulse (lap_pulse)
   );

   // Any departure from RUN drops the freeze so the display never lingers on a stale lap.
   always_ff @(posedge clk) begin
      if (reset) begin
         lap_active <= 1'b0;
         lap_min    <= '0;
         lap_sec    <= '0;
      end else if (nxt != ST_RUN) begin
         lap_active <= 1'b0;
      end else if (lap_pulse && state == ST_RUN) begin
         lap_active <= ~lap_active;
         if (!lap_active) begin
            lap_min <= live_min;
            lap_sec <= live_sec;
         end
      end
   end

   assign minutes   = lap_active ? lap_min : live_min;
   assign seconds   = lap_active ? lap_sec : live_sec;
   assign lapActive = lap_active;
`else
   assign minutes = live_min;
   assign seconds = live_sec;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter at CLK_FREQ=4, ADJ_DIV=2: table of input steps with queued expected outputs.
module tb_stopwatch_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pauseBtn = 1'b0;
   logic       adjust = 1'b0;
   logic       select = 1'b0;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       paused;
   logic       adjusting;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string name;
      int    cyc;
      logic  r;
      logic  b;
      logic  ad;
      logic  sl;
      int    m;
      int    s;
      logic  p;
      logic  a;
   } step_t;

   step_t exp_q[$];

   always #5 clk = ~clk;

   stopwatch_counter #(
      .CLK_FREQ (4),
      .ADJ_DIV  (2),
      .MAX_VAL  (59)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pauseBtn  (pauseBtn),
      .adjust    (adjust),
      .select    (select),
      .minutes   (minutes),
      .seconds   (seconds),
      .paused    (paused),
      .adjusting (adjusting)
   );

   // Inputs applied now, then cyc clocks, then the outputs must equal m:s/p/a.
   function automatic void push(input string name, input int cyc, input logic r, input logic b,
                                input logic ad, input logic sl, input int m, input int s,
                                input logic p, input logic a);
      step_t e;
      e.name = name; e.cyc = cyc; e.r = r; e.b = b; e.ad = ad; e.sl = sl;
      e.m = m; e.s = s; e.p = p; e.a = a;
      exp_q.push_back(e);
   endfunction

   task automatic test_reset();
      push("reset_state", 2, 1, 0, 0, 0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         step_t e = exp_q.pop_front();
         reset = e.r; pauseBtn = e.b; adjust = e.ad; select = e.sl;
         repeat (e.cyc) @(negedge clk);
         checks++;
         if ({minutes, seconds, paused, adjusting} !== {6'(e.m), 6'(e.s), e.p, e.a}) begin
            errors++;
            $display("FAIL %s: got %0d:%0d paused=%b adjusting=%b, expected %0d:%0d paused=%b adjusting=%b",
                     e.name, minutes, seconds, paused, adjusting, e.m, e.s, e.p, e.a);
         end
      end
   endtask

   task automatic test_run_wrap();
      push("run_before_tick", 3, 0, 0, 0, 0, 0, 0, 0, 0);
      push("run_first_tick", 1, 0, 0, 0, 0, 0, 1, 0, 0);
      push("run_sixty_sec", 236, 0, 0, 0, 0, 1, 0, 0, 0);
      while (exp_q.size() > 0) begin
         step_t e = exp_q.pop_front();
         reset = e.r; pauseBtn = e.b; adjust = e.ad; select = e.sl;
         for (int i = 0; i < e.cyc; i++) begin
            @(negedge clk);
            checks++;
            if (paused !== 1'b0 || adjusting !== 1'b0) begin
               errors++;
               $display("FAIL run_status: got paused=%b adjusting=%b, expected 0 0", paused, adjusting);
            end
         end
         checks++;
         if ({minutes, seconds, paused, adjusting} !== {6'(e.m), 6'(e.s), e.p, e.a}) begin
            errors++;
            $display("FAIL %s: got %0d:%0d paused=%b adjusting=%b, expected %0d:%0d paused=%b adjusting=%b",
                     e.name, minutes, seconds, paused, adjusting, e.m, e.s, e.p, e.a);
         end
      end
   endtask

   task automatic test_pause();
      push("pz_reset", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      push("pz_run5", 20, 0, 0, 0, 0, 0, 5, 0, 0);
      push("pz_pause", 1, 0, 1, 0, 0, 0, 5, 1, 0);
      push("pz_hold100", 100, 0, 0, 0, 0, 0, 5, 1, 0);
      push("pz_resume", 1, 0, 1, 0, 0, 0, 5, 0, 0);
      push("pz_resume_3cyc", 3, 0, 0, 0, 0, 0, 5, 0, 0);
      push("pz_resume_4cyc", 1, 0, 0, 0, 0, 0, 6, 0, 0);
      while (exp_q.size() > 0) begin
         step_t e = exp_q.pop_front();
         reset = e.r; pauseBtn = e.b; adjust = e.ad; select = e.sl;
         repeat (e.cyc) @(negedge clk);
         checks++;
         if ({minutes, seconds, paused, adjusting} !== {6'(e.m), 6'(e.s), e.p, e.a}) begin
            errors++;
            $display("FAIL %s: got %0d:%0d paused=%b adjusting=%b, expected %0d:%0d paused=%b adjusting=%b",
                     e.name, minutes, seconds, paused, adjusting, e.m, e.s, e.p, e.a);
         end
      end
   endtask

   task automatic test_adjust();
      push("adj_reset", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      push("adj_min58", 117, 0, 0, 1, 0, 58, 0, 0, 1);
      push("adj_sec30", 60, 0, 0, 1, 1, 58, 30, 0, 1);
      push("adj_min59", 2, 0, 0, 1, 0, 59, 30, 0, 1);
      push("adj_min_wrap", 2, 0, 0, 1, 0, 0, 30, 0, 1);
      push("adj_exit_paused", 1, 0, 0, 0, 0, 0, 30, 1, 0);
      while (exp_q.size() > 0) begin
         step_t e = exp_q.pop_front();
         reset = e.r; pauseBtn = e.b; adjust = e.ad; select = e.sl;
         repeat (e.cyc) @(negedge clk);
         checks++;
         if ({minutes, seconds, paused, adjusting} !== {6'(e.m), 6'(e.s), e.p, e.a}) begin
            errors++;
            $display("FAIL %s: got %0d:%0d paused=%b adjusting=%b, expected %0d:%0d paused=%b adjusting=%b",
                     e.name, minutes, seconds, paused, adjusting, e.m, e.s, e.p, e.a);
         end
      end
   endtask

   task automatic test_preload_wrap();
      push("pw_reset", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      push("pw_min59", 119, 0, 0, 1, 0, 59, 0, 0, 1);
      push("pw_sec58", 116, 0, 0, 1, 1, 59, 58, 0, 1);
      push("pw_exit", 1, 0, 0, 0, 0, 59, 58, 1, 0);
      push("pw_resume", 1, 0, 1, 0, 0, 59, 58, 0, 0);
      push("pw_5959", 4, 0, 0, 0, 0, 59, 59, 0, 0);
      push("pw_0000", 4, 0, 0, 0, 0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         step_t e = exp_q.pop_front();
         reset = e.r; pauseBtn = e.b; adjust = e.ad; select = e.sl;
         repeat (e.cyc) @(negedge clk);
         checks++;
         if ({minutes, seconds, paused, adjusting} !== {6'(e.m), 6'(e.s), e.p, e.a}) begin
            errors++;
            $display("FAIL %s: got %0d:%0d paused=%b adjusting=%b, expected %0d:%0d paused=%b adjusting=%b",
                     e.name, minutes, seconds, paused, adjusting, e.m, e.s, e.p, e.a);
         end
      end
   endtask

   task automatic test_pause_adjust_same();
      push("pa_reset", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      push("pa_both", 1, 0, 1, 1, 0, 0, 0, 0, 1);
      push("pa_exit", 1, 0, 1, 0, 0, 0, 0, 1, 0);
      while (exp_q.size() > 0) begin
         step_t e = exp_q.pop_front();
         reset = e.r; pauseBtn = e.b; adjust = e.ad; select = e.sl;
         repeat (e.cyc) @(negedge clk);
         checks++;
         if ({minutes, seconds, paused, adjusting} !== {6'(e.m), 6'(e.s), e.p, e.a}) begin
            errors++;
            $display("FAIL %s: got %0d:%0d paused=%b adjusting=%b, expected %0d:%0d paused=%b adjusting=%b",
                     e.name, minutes, seconds, paused, adjusting, e.m, e.s, e.p, e.a);
         end
      end
   endtask

   task automatic test_reset_mid_adjust();
      push("rm_reset", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      push("rm_min12", 25, 0, 0, 1, 0, 12, 0, 0, 1);
      push("rm_sec34", 68, 0, 0, 1, 1, 12, 34, 0, 1);
      push("rm_reset_in_adjust", 1, 1, 0, 1, 1, 0, 0, 0, 0);
      push("rm_release_3cyc", 3, 0, 0, 0, 0, 0, 0, 0, 0);
      push("rm_release_4cyc", 1, 0, 0, 0, 0, 0, 1, 0, 0);
      while (exp_q.size() > 0) begin
         step_t e = exp_q.pop_front();
         reset = e.r; pauseBtn = e.b; adjust = e.ad; select = e.sl;
         repeat (e.cyc) @(negedge clk);
         checks++;
         if ({minutes, seconds, paused, adjusting} !== {6'(e.m), 6'(e.s), e.p, e.a}) begin
            errors++;
            $display("FAIL %s: got %0d:%0d paused=%b adjusting=%b, expected %0d:%0d paused=%b adjusting=%b",
                     e.name, minutes, seconds, paused, adjusting, e.m, e.s, e.p, e.a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_run_wrap();
      test_pause();
      test_adjust();
      test_preload_wrap();
      test_pause_adjust_same();
      test_reset_mid_adjust();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
